sync_mod10_counter: RTL and testbench



---
 rtl/sync_mod10_counter.sv | 43 ++++
 tb/tb_sync_mod10_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_mod10_counter.sv
// Synchronous modulo-MODULUS up-counter (default decade digit) with a registered
// count, explicit-compare wrap, illegal-state recovery and a decoded terminal count.
module sync_mod10_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
        $error("sync_mod10_counter: MODULUS must lie in 2 .. 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    // Using >= rather than == folds wrap and recovery from codes >= MODULUS into one compare.
    always_comb begin
        // NOTE: default assigned first so every path drives count_next and no latch is inferred.
        count_next = count + WIDTH'(1);
        if (count >= LAST) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment for state so all flops update together on the edge.
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign q  = count;
    assign tc = (count == LAST);

endmodule

// File: tb/tb_sync_mod10_counter.sv
// Directed self-checking bench for sync_mod10_counter: default decade instance plus
// MODULUS=16/WIDTH=4 and MODULUS=6/WIDTH=3 instances sharing clock and reset.
module tb_sync_mod10_counter;

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic       tc;
    logic [3:0] q16;
    logic       tc16;
    logic [2:0] q6;
    logic       tc6;

    int tests_run    = 0;
    int tests_failed = 0;

    sync_mod10_counter dut (
        .clk (clk),
        .rst (rst),
        .q   (q),
        .tc  (tc)
    );

    sync_mod10_counter #(.MODULUS(16), .WIDTH(4)) dut_m16 (
        .clk (clk),
        .rst (rst),
        .q   (q16),
        .tc  (tc16)
    );

    sync_mod10_counter #(.MODULUS(6), .WIDTH(3)) dut_m6 (
        .clk (clk),
        .rst (rst),
        .q   (q6),
        .tc  (tc6)
    );

    // 20-unit period: rising edges at 10, 30, 50, ...; falling edges at 20, 40, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_t0: q=%0d tc=%b, expected q=0 tc=0", q, tc);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (q !== 4'd0 || tc !== 1'b0 || q16 !== 4'd0 || q6 !== 3'd0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: q=%0d tc=%b q16=%0d q6=%0d, expected all 0",
                         i, q, tc, q16, q6);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        logic [3:0] exp_q;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            exp_q = 4'((i + 1) % 10);
            tests_run++;
            if (q !== exp_q || tc !== (exp_q == 4'd9)) begin
                tests_failed++;
                $display("FAIL sequence[%0d]: q=%0d tc=%b, expected q=%0d tc=%b",
                         i, q, tc, exp_q, (exp_q == 4'd9));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        tests_run++;
        if (q !== 4'd6) begin
            tests_failed++;
            $display("FAIL async_pre: q=%0d, expected 6", q);
        end
        #5 rst = 1'b1;
        #1;
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_clear: q=%0d tc=%b, expected q=0 tc=0 before next edge", q, tc);
        end
        @(negedge clk);
        tests_run++;
        if (q !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_hold: q=%0d, expected 0", q);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (q !== 4'd1) begin
            tests_failed++;
            $display("FAIL async_release: q=%0d, expected 1", q);
        end
    endtask

    task automatic test_reset_pulsing();
        @(posedge clk);
        #5 rst = 1'b1;
        #5;
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_hi1: q=%0d tc=%b, expected q=0 tc=0", q, tc);
        end
        #5 rst = 1'b0;
        #2;
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_lo1: q=%0d tc=%b, expected q=0 tc=0", q, tc);
        end
        #5;
        tests_run++;
        if (q !== 4'd1 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_edge1: q=%0d tc=%b, expected q=1 tc=0", q, tc);
        end
        #3 rst = 1'b1;
        #2;
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_hi2: q=%0d tc=%b, expected q=0 tc=0", q, tc);
        end
        #8 rst = 1'b0;
        #2;
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_lo2: q=%0d tc=%b, expected q=0 tc=0", q, tc);
        end
        #5;
        tests_run++;
        if (q !== 4'd1 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_edge2: q=%0d tc=%b, expected q=1 tc=0", q, tc);
        end
        #3;
    endtask

    task automatic test_illegal_state();
        @(negedge clk);
        force dut.count = 4'd12;
        #1;
        tests_run++;
        if (q !== 4'd12 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_forced: q=%0d tc=%b, expected q=12 tc=0", q, tc);
        end
        release dut.count;
        @(negedge clk);
        tests_run++;
        if (q !== 4'd0) begin
            tests_failed++;
            $display("FAIL illegal_recover: q=%0d, expected 0", q);
        end
        @(negedge clk);
        tests_run++;
        if (q !== 4'd1) begin
            tests_failed++;
            $display("FAIL illegal_resume: q=%0d, expected 1", q);
        end
    endtask

    task automatic test_param_sweep();
        logic [3:0] exp16;
        logic [2:0] exp6;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            exp16 = 4'((i + 1) % 16);
            exp6  = 3'((i + 1) % 6);
            tests_run++;
            if (q16 !== exp16 || tc16 !== (exp16 == 4'd15)) begin
                tests_failed++;
                $display("FAIL sweep_m16[%0d]: q=%0d tc=%b, expected q=%0d tc=%b",
                         i, q16, tc16, exp16, (exp16 == 4'd15));
            end
            tests_run++;
            if (q6 !== exp6 || tc6 !== (exp6 == 3'd5)) begin
                tests_failed++;
                $display("FAIL sweep_m6[%0d]: q=%0d tc=%b, expected q=%0d tc=%b",
                         i, q6, tc6, exp6, (exp6 == 3'd5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_async_reset();
        test_reset_pulsing();
        test_illegal_state();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
